// File: rtl/score_digit_renderer.sv
// Two-digit score overlay: sequential binary-to-decimal conversion plus a
// two-stage pixel pipeline that addresses an external character ROM.
module score_digit_renderer #(
    parameter int unsigned X0         = 16,
    parameter int unsigned Y0         = 16,
    parameter int unsigned SCALE_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       score_valid,
    input  logic [6:0] score,
    output logic       score_ready,
    input  logic       smiley,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       de,
    output logic [3:0] rom_number,
    output logic [2:0] rom_line,
    input  logic [7:0] rom_charline,
    output logic       pixel,
    output logic       pixel_de
);

    localparam logic [10:0] CELL_W  = 11'(8 << SCALE_LOG2);
    localparam logic [10:0] GAP_W   = 11'(1 << SCALE_LOG2);
    localparam logic [10:0] TENS_L  = 11'(X0);
    localparam logic [10:0] TENS_R  = TENS_L + CELL_W;
    localparam logic [10:0] UNITS_L = TENS_R + GAP_W;
    localparam logic [10:0] UNITS_R = UNITS_L + CELL_W;
    localparam logic [10:0] TOP     = 11'(Y0);
    localparam logic [10:0] BOTTOM  = TOP + CELL_W;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] rem_q, rem_d;
    logic [3:0] tacc_q, tacc_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;

    logic [3:0] num_q, num_d;
    logic [2:0] line_q, line_d;
    logic [2:0] col_q, col_d;
    logic       hit_q, hit_d;
    logic       de_q;
    logic       pixel_q, pixel_de_q;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (score_valid) state_d = CONVERT;
            CONVERT: if (rem_q < 7'd10) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        score_ready = (state_q == IDLE);
    end

    always_comb begin
        rem_d   = rem_q;
        tacc_d  = tacc_q;
        tens_d  = tens_q;
        units_d = units_q;
        case (state_q)
            IDLE: begin
                if (score_valid) begin
                    rem_d  = (score > 7'd99) ? 7'd99 : score;
                    tacc_d = '0;
                end
            end
            CONVERT: begin
                if (rem_q >= 7'd10) begin
                    rem_d  = rem_q - 7'd10;
                    tacc_d = tacc_q + 4'd1;
                end else begin
                    tens_d  = tacc_q;
                    units_d = rem_q[3:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_q   <= '0;
            tacc_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            rem_q   <= rem_d;
            tacc_q  <= tacc_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    // ---------------- stage 1: cell decode and ROM addressing ----------------
    logic [10:0] x_e, y_e, cell_left, dx, dy, dx_sh, dy_sh;
    logic        in_y, in_tens, in_units, tens_hit, units_hit;
    logic        unused_bits;

    always_comb begin
        x_e       = {1'b0, x};
        y_e       = {1'b0, y};
        in_y      = (y_e >= TOP) && (y_e < BOTTOM);
        in_tens   = (x_e >= TENS_L) && (x_e < TENS_R);
        in_units  = (x_e >= UNITS_L) && (x_e < UNITS_R);
        // Tens cell is suppressed for a leading zero and in smiley mode.
        tens_hit  = in_y && in_tens && !smiley && (tens_q != 4'd0);
        units_hit = in_y && in_units;
        hit_d     = de && (tens_hit || units_hit);
        cell_left = in_tens ? TENS_L : UNITS_L;
        dx        = x_e - cell_left;
        dy        = y_e - TOP;
        dx_sh     = dx >> SCALE_LOG2;
        dy_sh     = dy >> SCALE_LOG2;

        num_d  = num_q;
        line_d = line_q;
        col_d  = col_q;
        if (hit_d) begin
            num_d  = units_hit ? (smiley ? 4'd10 : units_q) : tens_q;
            line_d = dy_sh[2:0];
            col_d  = dx_sh[2:0];
        end
    end

    assign unused_bits = &{1'b0, dx_sh[10:3], dy_sh[10:3]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_q  <= '0;
            line_q <= '0;
            col_q  <= '0;
            hit_q  <= 1'b0;
            de_q   <= 1'b0;
        end else begin
            num_q  <= num_d;
            line_q <= line_d;
            col_q  <= col_d;
            hit_q  <= hit_d;
            de_q   <= de;
        end
    end

    // ---------------- stage 2: pixel select ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixel_q    <= 1'b0;
            pixel_de_q <= 1'b0;
        end else begin
            pixel_q    <= hit_q && rom_charline[col_q];
            pixel_de_q <= de_q;
        end
    end

    assign rom_number = num_q;
    assign rom_line   = line_q;
    assign pixel      = pixel_q;
    assign pixel_de   = pixel_de_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Self-checking bench: two renderer instances (scale 4x and 1x) driven in
// parallel and compared every cycle against a geometric reference model.
module tb_score_digit_renderer;

    localparam int OX = 16;
    localparam int OY = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       score_valid;
    logic [6:0] score;
    logic       smiley;
    logic [9:0] x, y;
    logic       de;

    logic       ready_a, ready_b;
    logic [3:0] num_a, num_b;
    logic [2:0] line_a, line_b;
    logic [7:0] chr_a, chr_b;
    logic       pix_a, pix_b, pde_a, pde_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] font_row(input logic [3:0] code, input logic [2:0] line);
        logic [63:0] g;
        int          li;
        case (code)
            4'd0:  g = {8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00};
            4'd1:  g = {8'h18, 8'h1C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};
            4'd2:  g = {8'h3C, 8'h66, 8'h60, 8'h30, 8'h0C, 8'h06, 8'h7E, 8'h00};
            4'd3:  g = {8'h3C, 8'h66, 8'h60, 8'h38, 8'h60, 8'h66, 8'h3C, 8'h00};
            4'd4:  g = {8'h30, 8'h38, 8'h34, 8'h32, 8'h7E, 8'h30, 8'h30, 8'h00};
            4'd5:  g = {8'h7E, 8'h06, 8'h3E, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00};
            4'd6:  g = {8'h3C, 8'h06, 8'h3E, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00};
            4'd7:  g = {8'h7E, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h0C, 8'h0C, 8'h00};
            4'd8:  g = {8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00};
            4'd9:  g = {8'h3C, 8'h66, 8'h66, 8'h7C, 8'h60, 8'h66, 8'h3C, 8'h00};
            4'd10: g = {8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h42, 8'h7E};
            default: g = '0;
        endcase
        li = 7 - int'(line);
        return g[li*8 +: 8];
    endfunction

    // Expected overlay bit for one beam position, straight from cell geometry.
    function automatic bit exp_pix(input int s, input int xx, input int yy, input bit dee,
                                   input bit sm, input int t, input int u);
        int w, g, line, code, left;
        logic [7:0] row;
        w = 8 << s;
        g = 1 << s;
        if (!dee) return 1'b0;
        if (yy < OY || yy >= OY + w) return 1'b0;
        line = (yy - OY) >> s;
        if (xx >= OX && xx < OX + w) begin
            if (sm || t == 0) return 1'b0;
            code = t;
            left = OX;
        end else if (xx >= OX + w + g && xx < OX + 2*w + g) begin
            code = sm ? 10 : u;
            left = OX + w + g;
        end else begin
            return 1'b0;
        end
        row = font_row(4'(code), 3'(line));
        return row[(xx - left) >> s];
    endfunction

    assign chr_a = font_row(num_a, line_a);
    assign chr_b = font_row(num_b, line_b);

    score_digit_renderer #(.X0(OX), .Y0(OY), .SCALE_LOG2(2)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .score_valid(score_valid), .score(score),
        .score_ready(ready_a), .smiley(smiley), .x(x), .y(y), .de(de),
        .rom_number(num_a), .rom_line(line_a), .rom_charline(chr_a),
        .pixel(pix_a), .pixel_de(pde_a)
    );

    score_digit_renderer #(.X0(OX), .Y0(OY), .SCALE_LOG2(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .score_valid(score_valid), .score(score),
        .score_ready(ready_b), .smiley(smiley), .x(x), .y(y), .de(de),
        .rom_number(num_b), .rom_line(line_b), .rom_charline(chr_b),
        .pixel(pix_b), .pixel_de(pde_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t x=%0d y=%0d)", name, act, exp, $time, x, y);
        end
    endtask

    // Reference model: digits committed 1+s/10 edges after accept, pixel 2 edges after x/y.
    int tens_m = 0, units_m = 0, pend_t = 0, pend_u = 0, left_m = 0;
    bit busy_m = 1'b0;
    bit pa1 = 0, pa2 = 0, pb1 = 0, pb2 = 0, d1 = 0, d2 = 0;

    always @(posedge clk) begin
        int s;
        if (!reset_n) begin
            tens_m = 0; units_m = 0; busy_m = 1'b0; left_m = 0;
            pa1 = 0; pa2 = 0; pb1 = 0; pb2 = 0; d1 = 0; d2 = 0;
        end else begin
            pa2 = pa1; pb2 = pb1; d2 = d1;
            pa1 = exp_pix(2, int'(x), int'(y), de, smiley, tens_m, units_m);
            pb1 = exp_pix(0, int'(x), int'(y), de, smiley, tens_m, units_m);
            d1  = de;
            if (busy_m) begin
                left_m--;
                if (left_m == 0) begin
                    tens_m = pend_t; units_m = pend_u; busy_m = 1'b0;
                end
            end else if (score_valid) begin
                s = (int'(score) > 99) ? 99 : int'(score);
                pend_t = s / 10; pend_u = s % 10;
                left_m = 1 + s / 10;
                busy_m = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pixel_x4",    int'(pix_a),   int'(pa2));
            check("pixel_de_x4", int'(pde_a),   int'(d2));
            check("pixel_x1",    int'(pix_b),   int'(pb2));
            check("pixel_de_x1", int'(pde_b),   int'(d2));
            check("ready_x4",    int'(ready_a), int'(!busy_m));
            check("ready_x1",    int'(ready_b), int'(!busy_m));
        end
    end

    task automatic frame(input bit sm0, input int sm_flip, input int inj_at, input int inj_score);
        int idx = 0;
        for (int yy = 12; yy < 52; yy++) begin
            for (int xx = 8; xx < 96; xx++) begin
                @(negedge clk);
                x           = 10'(xx);
                y           = 10'(yy);
                de          = (xx < 92) && !(xx == 20 && yy == 30);
                smiley      = (sm_flip >= 0 && idx >= sm_flip) ? !sm0 : sm0;
                score_valid = (idx == inj_at);
                score       = 7'(inj_score);
                idx++;
            end
        end
        @(negedge clk);
        x = 10'd639; y = 10'd479; de = 1'b1; score_valid = 1'b0;
        @(negedge clk);
        de = 1'b0; x = '0; y = '0; smiley = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic offer(input int s, input int exp_lat, input int exp_t, input int exp_u);
        int cnt = 0;
        @(negedge clk);
        score_valid = 1'b1;
        score       = 7'(s);
        @(negedge clk);
        score_valid = 1'b0;
        while (!ready_a && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", cnt, exp_lat);
        check("model_tens", tens_m, exp_t);
        check("model_units", units_m, exp_u);
    endtask

    task automatic load_test();
        int cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            score_valid = 1'b1;
            score       = 7'((i * 37 + 11) % 128);
        end
        @(negedge clk);
        score_valid = 1'b0;
        while (!ready_a && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("load_drain", int'(cnt < 40), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; score_valid = 1'b0; score = '0; smiley = 1'b0;
        x = '0; y = '0; de = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", int'(ready_a), 1);
        check("reset_pixel", int'(pix_a), 0);
        check("reset_pixel_de", int'(pde_a), 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Hand-computed pins on the reference model.
        check("pin_5_line0_col1", int'(exp_pix(2, 20, 16, 1, 0, 5, 7)), 1);
        check("pin_5_line0_col0", int'(exp_pix(2, 16, 16, 1, 0, 5, 7)), 0);
        check("pin_gap",          int'(exp_pix(2, 49, 20, 1, 0, 5, 7)), 0);
        check("pin_7_line0_col1", int'(exp_pix(2, 56, 16, 1, 0, 5, 7)), 1);
        check("pin_line7_blank",  int'(exp_pix(2, 20, 45, 1, 0, 5, 7)), 0);
        check("pin_lead_zero",    int'(exp_pix(2, 20, 16, 1, 0, 0, 7)), 0);
        check("pin_smiley_x56",   int'(exp_pix(2, 56, 44, 1, 1, 4, 2)), 1);
        check("pin_smiley_x52",   int'(exp_pix(2, 52, 44, 1, 1, 4, 2)), 0);
        check("pin_smiley_x79",   int'(exp_pix(2, 79, 47, 1, 1, 4, 2)), 1);
        check("pin_smiley_x80",   int'(exp_pix(2, 80, 44, 1, 1, 4, 2)), 0);
        check("pin_x1_col1",      int'(exp_pix(0, 17, 16, 1, 0, 5, 7)), 1);
        check("pin_de_low",       int'(exp_pix(2, 20, 16, 0, 0, 5, 7)), 0);

        offer(0, 1, 0, 0);
        frame(1'b0, -1, -1, 0);
        offer(9, 1, 0, 9);
        frame(1'b0, -1, -1, 0);
        offer(10, 2, 1, 0);
        frame(1'b0, -1, -1, 0);
        offer(99, 10, 9, 9);
        frame(1'b0, -1, -1, 0);
        offer(120, 10, 9, 9);
        offer(57, 6, 5, 7);
        frame(1'b0, -1, -1, 0);
        offer(7, 1, 0, 7);
        frame(1'b0, -1, -1, 0);

        offer(42, 5, 4, 2);
        frame(1'b1, -1, -1, 0);
        frame(1'b1, 28 * 88 + 50, -1, 0);

        load_test();
        frame(1'b0, -1, -1, 0);

        // Commit lands mid-row inside the cells of both instances.
        frame(1'b0, -1, 6 * 88 + 2, 83);
        check("midframe_tens", tens_m, 8);
        check("midframe_units", units_m, 3);

        @(negedge clk);
        score_valid = 1'b1; score = 7'd87;
        @(negedge clk);
        score_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("abort_ready", int'(ready_a), 1);
        check("abort_pixel", int'(pix_a), 0);
        check("abort_pixel_de", int'(pde_a), 0);
        frame(1'b0, -1, -1, 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
